// File: rtl/bg_layer_pkg.sv
// bg_layer_pkg: shared types, defaults and helpers for the background layer renderer
package bg_layer_pkg;
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;
    localparam int KEY_INDEX_DEF = 0;
    function automatic int addr_w(input int w_log2, input int h_log2);
        return w_log2 + h_log2;
    endfunction
endpackage

// File: rtl/bg_layer_renderer_if.sv
// bg_layer_renderer_if: pixel, configuration, ROM and palette signals of the background layer
interface bg_layer_renderer_if import bg_layer_pkg::*; #(
    parameter int IMG_W_LOG2 = 5,
    parameter int IMG_H_LOG2 = 5,
    parameter int IDX_W      = 4
);
    localparam int AW = addr_w(IMG_W_LOG2, IMG_H_LOG2);
    logic [9:0]            DrawX;
    logic [9:0]            DrawY;
    logic                  blank;
    logic [9:0]            org_x;
    logic [9:0]            org_y;
    logic [IMG_W_LOG2-1:0] scroll_x;
    logic [IMG_H_LOG2-1:0] scroll_y;
    logic                  wrap;
    logic [AW-1:0]         rom_addr;
    logic [IDX_W-1:0]      rom_q;
    logic                  pal_we;
    logic [IDX_W-1:0]      pal_waddr;
    logic [11:0]           pal_wdata;
    logic [3:0]            red;
    logic [3:0]            green;
    logic [3:0]            blue;
    logic                  opaque;
    modport slave (
        input  DrawX, DrawY, blank, org_x, org_y, scroll_x, scroll_y, wrap,
        input  rom_q, pal_we, pal_waddr, pal_wdata,
        output rom_addr, red, green, blue, opaque
    );
    modport master (
        output DrawX, DrawY, blank, org_x, org_y, scroll_x, scroll_y, wrap,
        output rom_q, pal_we, pal_waddr, pal_wdata,
        input  rom_addr, red, green, blue, opaque
    );
endinterface

// File: rtl/bg_palette.sv
// bg_palette: RGB444 register file with synchronous write and combinational read
module bg_palette import bg_layer_pkg::*; #(
    parameter int IDX_W = 4
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [11:0]      i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output rgb444_t          o_rdata
);
    logic [11:0] r_mem [2**IDX_W];
    always_ff @(posedge vga_clk) begin
        if (reset) r_mem <= '{default: '0};
        else if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/bg_layer_renderer.sv
// bg_layer_renderer: 3-stage scaled/scrolled background layer with palette and transparency key
module bg_layer_renderer import bg_layer_pkg::*; #(
    parameter int IMG_W_LOG2  = 5,
    parameter int IMG_H_LOG2  = 5,
    parameter int SCALE_SHIFT = 4,
    parameter int IDX_W       = 4,
    parameter int KEY_INDEX   = KEY_INDEX_DEF,
    parameter int V_ACTIVE    = 480
) (
    input logic vga_clk,
    input logic reset,
    bg_layer_renderer_if.slave bus
);
    localparam int AW = addr_w(IMG_W_LOG2, IMG_H_LOG2);
    logic [9:0]            r_ox, r_oy;
    logic [IMG_W_LOG2-1:0] r_sx;
    logic [IMG_H_LOG2-1:0] r_sy;
    logic                  r_wr;
    logic [9:0]            w_rx, w_ry, w_tx, w_ty;
    logic                  w_inr, w_hit;
    logic [IMG_W_LOG2-1:0] w_u;
    logic [IMG_H_LOG2-1:0] w_v;
    logic [AW-1:0]         r_rom_addr;
    logic                  r_blank_d1, r_inr_d1, r_blank_d2, r_inr_d2, r_opaque;
    rgb444_t               r_rgb, w_pal;
    assign w_rx = bus.DrawX - r_ox;
    assign w_ry = bus.DrawY - r_oy;
    assign w_tx = w_rx >> SCALE_SHIFT;
    assign w_ty = w_ry >> SCALE_SHIFT;
    // range test uses the untruncated texel coordinate so clamp mode stops at the image edge
    assign w_inr = r_wr | (bus.DrawX >= r_ox && bus.DrawY >= r_oy &&
                           {1'b0, w_tx} < (11'd1 << IMG_W_LOG2) &&
                           {1'b0, w_ty} < (11'd1 << IMG_H_LOG2));
    assign w_u = w_tx[IMG_W_LOG2-1:0] + r_sx;
    assign w_v = w_ty[IMG_H_LOG2-1:0] + r_sy;
    assign w_hit = r_blank_d2 && r_inr_d2 && bus.rom_q != IDX_W'(KEY_INDEX);
    bg_palette #(.IDX_W(IDX_W)) u_pal (
        .vga_clk (vga_clk),
        .reset   (reset),
        .i_we    (bus.pal_we),
        .i_waddr (bus.pal_waddr),
        .i_wdata (bus.pal_wdata),
        .i_raddr (bus.rom_q),
        .o_rdata (w_pal)
    );
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_ox <= '0;
            r_oy <= '0;
            r_sx <= '0;
            r_sy <= '0;
            r_wr <= 1'b0;
        end else if (bus.DrawX == 10'd0 && bus.DrawY == 10'(V_ACTIVE)) begin
            r_ox <= bus.org_x;
            r_oy <= bus.org_y;
            r_sx <= bus.scroll_x;
            r_sy <= bus.scroll_y;
            r_wr <= bus.wrap;
        end
    end
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_rom_addr <= '0;
            r_blank_d1 <= 1'b0;
            r_inr_d1   <= 1'b0;
            r_blank_d2 <= 1'b0;
            r_inr_d2   <= 1'b0;
            r_opaque   <= 1'b0;
            r_rgb      <= '0;
        end else begin
            r_rom_addr <= {w_v, w_u};
            r_blank_d1 <= bus.blank;
            r_inr_d1   <= w_inr;
            r_blank_d2 <= r_blank_d1;
            r_inr_d2   <= r_inr_d1;
            r_opaque   <= w_hit;
            r_rgb      <= w_hit ? w_pal : '0;
        end
    end
    assign bus.rom_addr = r_rom_addr;
    assign bus.red      = r_rgb.r;
    assign bus.green    = r_rgb.g;
    assign bus.blue     = r_rgb.b;
    assign bus.opaque   = r_opaque;
endmodule

// File: doc/bg_layer_renderer.md
# bg_layer_renderer

Parametrised background-layer pixel generator for the VGA path. Given the current `DrawX`/`DrawY`, it produces one layer pixel three clocks later. The pixel comes from an external synchronous image ROM, scaled by a power of two, positioned at a programmable origin, and scrolled by a per-frame-latched offset. Colour is resolved through a run-time-writable palette with a transparency key. Its output feeds the layer compositor in the colour mapper, and it supersedes the fixed 32×32 full-screen background renderer.

## Interface
Parameters:
- `IMG_W_LOG2`, 5: image width = 2^IMG_W_LOG2 texels.
- `IMG_H_LOG2`, 5: image height = 2^IMG_H_LOG2 texels.
- `SCALE_SHIFT`, 4: each texel covers 2^SCALE_SHIFT × 2^SCALE_SHIFT screen pixels.
- `IDX_W`, 4: palette index width; the palette has 2^IDX_W entries.
- `KEY_INDEX`, 0: palette index treated as transparent.
- `V_ACTIVE`, 480: first non-visible line; scroll and origin are latched there.

Ports:
- `vga_clk`, in, 1: pixel clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `DrawX`, `DrawY`, in, 10 each: current pixel coordinate.
- `blank`, in, 1: high means a visible pixel.
- `org_x`, `org_y`, in, 10 each: screen position of the image's top-left corner (pending value).
- `scroll_x`, in, IMG_W_LOG2: texel scroll offset (pending value).
- `scroll_y`, in, IMG_H_LOG2: texel scroll offset (pending value).
- `wrap`, in, 1: 1 = tile the image across the whole screen; 0 = draw a single copy (clamp).
- `rom_addr`, out, IMG_W_LOG2+IMG_H_LOG2: registered ROM address.
- `rom_q`, in, IDX_W: ROM data. The ROM is synchronous with one-cycle read latency.
- `pal_we`, in, 1: palette write enable.
- `pal_waddr`, in, IDX_W: palette write address.
- `pal_wdata`, in, 12: palette write data as {R[3:0], G[3:0], B[3:0]}.
- `red`, `green`, `blue`, out, 4 each: registered layer colour.
- `opaque`, out, 1: registered; 1 = the compositor uses this layer's pixel.

## Operation
- **Frame latch**
  - When `DrawX==0 && DrawY==V_ACTIVE`, the active registers `ox`, `oy`, `sx`, `sy`, `wr` load from `org_x/org_y/scroll_x/scroll_y/wrap`.
  - At all other times the active registers hold, so there is no mid-frame tearing.
  - Reset clears all active registers to 0.
- **Stage 1** (registered on edge n for the coordinate presented before edge n):
  - Relative coordinates: `rx = DrawX - ox` and `ry = DrawY - oy`, 10-bit modulo-1024 subtraction.
  - Texel coordinates: `tx = rx >> SCALE_SHIFT` and `ty = ry >> SCALE_SHIFT`.
  - In-range test: `inr = wr | (DrawX >= ox && DrawY >= oy && tx < 2^IMG_W_LOG2 && ty < 2^IMG_H_LOG2)`. The comparisons use the full-width `tx`/`ty` before truncation.
  - Address: `u = (tx + sx) mod 2^IMG_W_LOG2`, `v = (ty + sy) mod 2^IMG_H_LOG2`, and `rom_addr <= {v, u}` (row-major, so v is the high field).
  - `blank` and `inr` are registered alongside `rom_addr`.
- **Stage 2** (edge n+1): the ROM returns `rom_q`. `blank` and `inr` are delayed one more stage.
- **Stage 3** (edge n+2):
  - The palette is read combinationally from `rom_q`.
  - If `blank_d2 && inr_d2 && rom_q != KEY_INDEX`: `opaque <= 1` and RGB is loaded from the palette entry.
  - Otherwise: `opaque <= 0` and RGB <= 0.
- **Palette write**
  - When `pal_we`, the entry at `pal_waddr` takes `pal_wdata` on the edge.
  - A read of the same entry in the same cycle returns the old value; the new value is visible from the next cycle.
  - Writes are accepted at any time, including during the visible area.
- **Reset**
  - All palette entries, `rom_addr`, RGB, `opaque`, and the delay registers are 0.
  - Asserting reset mid-line forces `opaque=0` on the following edge.
  - The first valid output appears 3 edges after reset is released.

## Timing
- Latency from `DrawX`/`DrawY`/`blank` to RGB/`opaque` is exactly 3 `vga_clk` edges. Throughput is one pixel per clock with no stalls.
- `rom_addr` is valid 1 edge after its coordinate is presented. `rom_q` must be valid before edge n+2.
- The frame latch takes effect for line 0 of the next frame. A value that changes on the latch cycle itself is captured.
- Boundaries:
  - `rx` wraps negative when `DrawX < ox`. With `wr=0` this is excluded by the `DrawX >= ox` test; with `wr=1` it tiles.
  - The scroll add wraps modulo the image size.

## Structure
- Package `bg_layer_pkg`:
  - RGB444 struct.
  - Address width function.
  - Default `KEY_INDEX`.
- Sub-module `bg_palette`:
  - 2^IDX_W × 12-bit register file.
  - Synchronous write, combinational read, synchronous reset clear.
- Top level: frame latch, the three pipeline stages, and the output register.

## Test plan
Defaults for all scenarios: IMG 32×32, SCALE_SHIFT 4, ROM model holding `u^v` (low 4 bits), palette[i] = {i,i,i}.
1. **Reset.** Hold reset 4 cycles while driving random inputs -> `opaque=0`, RGB=0, `rom_addr=0` throughout, and for 2 cycles after release.
2. **Clamp.** Latch origin (100,50), scroll 0, `wrap=0`. Drive DrawX=99/100/611/612 at DrawY=50 -> `opaque` = 0/1/1/0, with `rom_addr` 0 at DrawX=100 and 31 at DrawX=611. Outputs appear 3 cycles later.
3. **Wrap and scroll.** Latch origin (0,0), scroll (31,1), `wrap=1`. At DrawX=0, DrawY=0 -> `rom_addr={5'd1,5'd31}`. At DrawX=528 -> `u=(33+31)&31=0`.
4. **Transparency.** Force `rom_q=KEY_INDEX` at a visible in-range pixel -> `opaque=0`, RGB=0. Set `blank=0` with a nonzero index -> `opaque=0`.
5. **Palette hazard.** Write palette[5]=12'hABC in the cycle that stage 3 reads index 5 -> old colour output. The next pixel with index 5 -> A/B/C.
6. **Frame latch.** Change `scroll_x` mid-frame at DrawY=200 -> no change to `rom_addr` until DrawY=480, DrawX=0. The new value applies from line 0 of the next frame.
